// File: rtl/vmcmp_ctrl_if.sv
// Handshake and data bundle between the vector mask-compare controller,
// its command/operand source, the compare unit and the mask writeback.
interface vmcmp_ctrl_if #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter int OPSEL_WIDTH = 3,
    parameter int VL_WIDTH    = 11
);
    logic                    cmd_valid;
    logic                    cmd_ready;
    logic [VL_WIDTH-1:0]     cmd_vl;
    logic [1:0]              cmd_sew;
    logic [OPSEL_WIDTH-1:0]  cmd_opSel;
    logic [ADDR_WIDTH-1:0]   cmd_vd_addr;

    logic                    src_valid;
    logic                    src_ready;
    logic [DATA_WIDTH-1:0]   src_vec0;
    logic [DATA_WIDTH-1:0]   src_vec1;

    logic                    cmp_in_valid;
    logic [DATA_WIDTH-1:0]   cmp_in_vec0;
    logic [DATA_WIDTH-1:0]   cmp_in_vec1;
    logic [2:0]              cmp_in_sew;
    logic [OPSEL_WIDTH-1:0]  cmp_in_opSel;
    logic [2:0]              cmp_in_start_idx;
    logic [ADDR_WIDTH-1:0]   cmp_in_addr;

    logic                    cmp_out_valid;
    logic [DATA_WIDTH-1:0]   cmp_out_vec;

    logic                    wb_valid;
    logic [ADDR_WIDTH-1:0]   wb_addr;
    logic [DATA_WIDTH-1:0]   wb_data;
    logic [DATA_WIDTH/8-1:0] wb_be;
    logic                    wb_last;

    logic                    busy;

    modport master (
        output cmd_valid, cmd_vl, cmd_sew, cmd_opSel, cmd_vd_addr,
        output src_valid, src_vec0, src_vec1,
        output cmp_out_valid, cmp_out_vec,
        input  cmd_ready, src_ready,
        input  cmp_in_valid, cmp_in_vec0, cmp_in_vec1, cmp_in_sew,
        input  cmp_in_opSel, cmp_in_start_idx, cmp_in_addr,
        input  wb_valid, wb_addr, wb_data, wb_be, wb_last, busy
    );

    modport slave (
        input  cmd_valid, cmd_vl, cmd_sew, cmd_opSel, cmd_vd_addr,
        input  src_valid, src_vec0, src_vec1,
        input  cmp_out_valid, cmp_out_vec,
        output cmd_ready, src_ready,
        output cmp_in_valid, cmp_in_vec0, cmp_in_vec1, cmp_in_sew,
        output cmp_in_opSel, cmp_in_start_idx, cmp_in_addr,
        output wb_valid, wb_addr, wb_data, wb_be, wb_last, busy
    );
endinterface

// File: rtl/vmcmp_ctrl.sv
// Vector mask-compare controller: issues operand beats to a compare unit and
// packs the returned per-element result bits into mask words for writeback.
module vmcmp_ctrl #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter int OPSEL_WIDTH = 3,
    parameter int VL_WIDTH    = 11
) (
    input logic         clk,
    input logic         rst,
    vmcmp_ctrl_if.slave bus
);
    localparam int LW = $clog2(DATA_WIDTH);
    localparam int RW = VL_WIDTH + 1;
    localparam int BW = DATA_WIDTH / 8;

    typedef logic [RW-1:0]         rc_t;
    typedef logic [VL_WIDTH-1:0]   vl_t;
    typedef logic [ADDR_WIDTH-1:0] ad_t;
    typedef logic [LW:0]           bw_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } state_t;

    state_t state_q, state_d;

    vl_t                   vl_q;
    logic [1:0]            sew_q;
    logic [OPSEL_WIDTH-1:0] opsel_q;
    ad_t                   vd_q;

    vl_t                   beat_q;
    rc_t                   ret_q;
    logic [DATA_WIDTH-1:0] acc_q;
    ad_t                   word_q;

    logic                  cin_valid_q;
    logic [DATA_WIDTH-1:0] cin_vec0_q;
    logic [DATA_WIDTH-1:0] cin_vec1_q;
    ad_t                   cin_addr_q;

    logic                  wb_valid_q;
    ad_t                   wb_addr_q;
    logic [DATA_WIDTH-1:0] wb_data_q;
    logic [BW-1:0]         wb_be_q;
    logic                  wb_last_q;

    logic                  cmd_fire;
    logic                  cmd_go;
    logic                  src_fire;
    logic                  res_fire;
    rc_t                   elem;
    rc_t                   beats;
    logic                  last_beat;
    rc_t                   rem;
    logic [7:0]            lane;
    logic [7:0]            res_bits;
    logic [DATA_WIDTH-1:0] acc_nx;
    rc_t                   ret_nx;
    logic                  fin;
    logic                  full;
    vl_t                   vlm1;
    bw_t                   fin_bits;
    bw_t                   fin_bytes;
    logic [BW-1:0]         be_fin;

    assign cmd_fire = bus.cmd_valid && (state_q == IDLE);
    assign cmd_go   = cmd_fire && (bus.cmd_vl != '0);
    assign src_fire = bus.src_valid && (state_q == ISSUE);
    assign res_fire = bus.cmp_out_valid && (state_q != IDLE);

    // Beat geometry: E = 8>>sew elements per beat, ceil(vl/E) beats.
    assign elem      = rc_t'(8) >> sew_q;
    assign beats     = (rc_t'(vl_q) + elem - rc_t'(1)) >> (2'd3 - sew_q);
    assign last_beat = (rc_t'(beat_q) == beats - rc_t'(1));

    assign rem = rc_t'(vl_q) - ret_q;

    always_comb begin
        lane = '0;
        for (int k = 0; k < 8; k++) begin
            lane[k] = (rc_t'(k) < elem) && (rc_t'(k) < rem);
        end
    end

    assign res_bits = bus.cmp_out_vec[7:0] & lane;
    assign acc_nx   = acc_q | (DATA_WIDTH'(res_bits) << ret_q[LW-1:0]);
    assign ret_nx   = ret_q + elem;
    assign fin      = (ret_nx >= rc_t'(vl_q));
    assign full     = (ret_nx[LW-1:0] == '0);

    // Valid bits in the final word, and the bytes that cover them.
    assign vlm1      = vl_q - vl_t'(1);
    assign fin_bits  = {1'b0, vlm1[LW-1:0]} + bw_t'(1);
    assign fin_bytes = (fin_bits + bw_t'(7)) >> 3;

    always_comb begin
        be_fin = '0;
        for (int b = 0; b < BW; b++) begin
            be_fin[b] = (bw_t'(b) < fin_bytes);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_go) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (src_fire && last_beat) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (wb_last_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vl_q        <= '0;
            sew_q       <= '0;
            opsel_q     <= '0;
            vd_q        <= '0;
            beat_q      <= '0;
            ret_q       <= '0;
            acc_q       <= '0;
            word_q      <= '0;
            cin_valid_q <= 1'b0;
            cin_vec0_q  <= '0;
            cin_vec1_q  <= '0;
            cin_addr_q  <= '0;
            wb_valid_q  <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            wb_be_q     <= '0;
            wb_last_q   <= 1'b0;
        end else begin
            cin_valid_q <= src_fire;
            wb_valid_q  <= 1'b0;
            wb_last_q   <= 1'b0;

            if (cmd_go) begin
                vl_q    <= bus.cmd_vl;
                sew_q   <= bus.cmd_sew;
                opsel_q <= bus.cmd_opSel;
                vd_q    <= bus.cmd_vd_addr;
                beat_q  <= '0;
                ret_q   <= '0;
                acc_q   <= '0;
                word_q  <= '0;
            end

            if (src_fire) begin
                cin_vec0_q <= bus.src_vec0;
                cin_vec1_q <= bus.src_vec1;
                cin_addr_q <= ad_t'(beat_q);
                beat_q     <= beat_q + vl_t'(1);
            end

            // A result that fills the word or retires the last element
            // flushes the accumulator one cycle later.
            if (res_fire) begin
                ret_q <= ret_nx;
                if (fin || full) begin
                    wb_valid_q <= 1'b1;
                    wb_addr_q  <= vd_q + word_q;
                    wb_data_q  <= acc_nx;
                    wb_be_q    <= fin ? be_fin : '1;
                    wb_last_q  <= fin;
                    acc_q      <= '0;
                    word_q     <= word_q + ad_t'(1);
                end else begin
                    acc_q <= acc_nx;
                end
            end
        end
    end

    assign bus.cmd_ready        = (state_q == IDLE);
    assign bus.busy             = (state_q != IDLE);
    assign bus.src_ready        = (state_q == ISSUE);
    assign bus.cmp_in_valid     = cin_valid_q;
    assign bus.cmp_in_vec0      = cin_vec0_q;
    assign bus.cmp_in_vec1      = cin_vec1_q;
    assign bus.cmp_in_sew       = {1'b0, sew_q};
    assign bus.cmp_in_opSel     = opsel_q;
    assign bus.cmp_in_start_idx = 3'd0;
    assign bus.cmp_in_addr      = cin_addr_q;
    assign bus.wb_valid         = wb_valid_q;
    assign bus.wb_addr          = wb_addr_q;
    assign bus.wb_data          = wb_data_q;
    assign bus.wb_be            = wb_be_q;
    assign bus.wb_last          = wb_last_q;
endmodule

// File: tb/tb_vmcmp_ctrl.sv
// Randomized bench for vmcmp_ctrl; the bench also plays the compare unit
// (eq for opSel 0, ne otherwise) and predicts mask words per element.
module tb_vmcmp_ctrl;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    vmcmp_ctrl_if #(
        .DATA_WIDTH (64),
        .ADDR_WIDTH (32),
        .OPSEL_WIDTH(3),
        .VL_WIDTH   (11)
    ) bus ();

    vmcmp_ctrl #(
        .DATA_WIDTH (64),
        .ADDR_WIDTH (32),
        .OPSEL_WIDTH(3),
        .VL_WIDTH   (11)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [63:0] v0;
        logic [63:0] v1;
    } beat_t;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] v0;
        logic [63:0] v1;
        logic [2:0]  sew;
        logic [2:0]  op;
    } cin_t;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  be;
        logic        last;
    } wb_t;

    beat_t       sent[$];
    cin_t        cin_obs[$];
    wb_t         wb_obs[$];
    logic [63:0] pend[$];
    int          resp_idx;
    int          cur_sew;
    int          cur_op;
    bit          saw_last;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit ref_bit(input beat_t b, input int k,
                                   input int sew, input int op);
        int          w;
        logic [63:0] m;
        logic [63:0] a;
        logic [63:0] c;
        w = 8 << sew;
        m = (sew == 3) ? '1 : ((64'd1 << w) - 64'd1);
        a = (b.v0 >> (k * w)) & m;
        c = (b.v1 >> (k * w)) & m;
        return (op == 0) ? (a == c) : (a != c);
    endfunction

    // Compare-unit stand-in: results in issue order, random latency,
    // garbage above the valid lanes.
    initial begin
        bus.cmp_out_valid = 1'b0;
        bus.cmp_out_vec   = '0;
        forever begin
            @(negedge clk);
            if (bus.cmp_in_valid && resp_idx < sent.size()) begin
                logic [63:0] r;
                int          e;
                r = {$urandom, $urandom};
                e = 8 >> cur_sew;
                for (int k = 0; k < e; k++)
                    r[k] = ref_bit(sent[resp_idx], k, cur_sew, cur_op);
                pend.push_back(r);
                resp_idx++;
            end
            if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
                bus.cmp_out_valid = 1'b1;
                bus.cmp_out_vec   = pend.pop_front();
            end else begin
                bus.cmp_out_valid = 1'b0;
                bus.cmp_out_vec   = {$urandom, $urandom};
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.cmp_in_valid)
                cin_obs.push_back('{bus.cmp_in_addr, bus.cmp_in_vec0,
                                    bus.cmp_in_vec1, bus.cmp_in_sew,
                                    bus.cmp_in_opSel});
            if (bus.wb_valid) begin
                wb_obs.push_back('{bus.wb_addr, bus.wb_data,
                                   bus.wb_be, bus.wb_last});
                if (bus.wb_last) saw_last = 1'b1;
            end
        end
    end

    task automatic start_cmd(input int vl, input int sew, input int op,
                             input logic [31:0] vd);
        sent.delete();
        cin_obs.delete();
        wb_obs.delete();
        resp_idx = 0;
        saw_last = 1'b0;
        cur_sew  = sew;
        cur_op   = op;
        @(negedge clk);
        chk("cmd_ready_idle", 64'(bus.cmd_ready), 64'd1);
        bus.cmd_valid   = 1'b1;
        bus.cmd_vl      = 11'(vl);
        bus.cmd_sew     = 2'(sew);
        bus.cmd_opSel   = 3'(op);
        bus.cmd_vd_addr = vd;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_vl    = 11'($urandom);
    endtask

    task automatic send_beat(input int i, input int mode, input int pat);
        logic [63:0] v0;
        logic [63:0] v1;
        v0 = {$urandom, $urandom};
        case (mode)
            0:       v1 = v0;
            1:       v1 = v0 ^ ({$urandom, $urandom} & {$urandom, $urandom}
                                & {$urandom, $urandom});
            default: v1 = pat[i] ? v0 : ~v0;
        endcase
        chk("src_ready", 64'(bus.src_ready), 64'd1);
        bus.src_valid = 1'b1;
        bus.src_vec0  = v0;
        bus.src_vec1  = v1;
        sent.push_back('{v0, v1});
    endtask

    task automatic run_cmd(input int vl, input int sew, input int op,
                           input logic [31:0] vd, input int mode,
                           input int pat);
        int e, nb, nw, i, t;
        e  = 8 >> sew;
        nb = (vl + e - 1) / e;
        nw = (vl + 63) / 64;
        start_cmd(vl, sew, op, vd);
        if (vl == 0) begin
            repeat (8) @(negedge clk);
            chk("vl0_busy", 64'(bus.busy), 64'd0);
            chk("vl0_cin", 64'(cin_obs.size()), 64'd0);
            chk("vl0_wb", 64'(wb_obs.size()), 64'd0);
            return;
        end
        chk("busy_run", 64'(bus.busy), 64'd1);
        chk("cmd_ready_run", 64'(bus.cmd_ready), 64'd0);
        i = 0;
        while (i < nb) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.src_valid = 1'b0;
            end else begin
                send_beat(i, mode, pat);
                i++;
            end
            @(negedge clk);
        end
        bus.src_valid = 1'b0;
        chk("src_ready_drain", 64'(bus.src_ready), 64'd0);
        chk("busy_drain", 64'(bus.busy), 64'd1);
        t = 0;
        while (!saw_last && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!saw_last) chk("wb_last_timeout", 64'd0, 64'd1);
        @(negedge clk);
        chk("busy_done", 64'(bus.busy), 64'd0);
        chk("cmd_ready_done", 64'(bus.cmd_ready), 64'd1);

        chk("cin_count", 64'(cin_obs.size()), 64'(nb));
        for (int b = 0; b < nb && b < cin_obs.size(); b++) begin
            chk("cin_addr", 64'(cin_obs[b].addr), 64'(b));
            chk("cin_vec0", cin_obs[b].v0, sent[b].v0);
            chk("cin_vec1", cin_obs[b].v1, sent[b].v1);
            chk("cin_sew", 64'(cin_obs[b].sew), 64'(sew));
            chk("cin_op", 64'(cin_obs[b].op), 64'(op));
        end

        chk("wb_count", 64'(wb_obs.size()), 64'(nw));
        for (int w = 0; w < nw && w < wb_obs.size(); w++) begin
            logic [63:0] d;
            logic [7:0]  be;
            int          n;
            d = '0;
            for (int bit_i = 0; bit_i < 64; bit_i++) begin
                int el;
                el = 64 * w + bit_i;
                if (el < vl)
                    d[bit_i] = ref_bit(sent[el / e], el % e, sew, op);
            end
            n  = vl - 64 * w;
            be = (n >= 64) ? 8'hFF : 8'((1 << ((n + 7) / 8)) - 1);
            chk("wb_addr", 64'(wb_obs[w].addr), 64'(vd + 32'(w)));
            chk("wb_data", wb_obs[w].data, d);
            chk("wb_be", 64'(wb_obs[w].be), 64'(be));
            chk("wb_last", 64'(wb_obs[w].last), 64'(w == nw - 1));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
        chk({tag, "_src_ready"}, 64'(bus.src_ready), 64'd0);
        chk({tag, "_cin_valid"}, 64'(bus.cmp_in_valid), 64'd0);
        chk({tag, "_cin_vec0"}, bus.cmp_in_vec0, 64'd0);
        chk({tag, "_cin_vec1"}, bus.cmp_in_vec1, 64'd0);
        chk({tag, "_cin_misc"},
            64'({bus.cmp_in_sew, bus.cmp_in_opSel, bus.cmp_in_start_idx}),
            64'd0);
        chk({tag, "_cin_addr"}, 64'(bus.cmp_in_addr), 64'd0);
        chk({tag, "_wb_valid"}, 64'(bus.wb_valid), 64'd0);
        chk({tag, "_wb_addr"}, 64'(bus.wb_addr), 64'd0);
        chk({tag, "_wb_data"}, bus.wb_data, 64'd0);
        chk({tag, "_wb_be_last"}, 64'({bus.wb_be, bus.wb_last}), 64'd0);
    endtask

    task automatic mid_reset_test();
        start_cmd(72, 0, 0, 32'h0000_1000);
        for (int i = 0; i < 2; i++) begin
            send_beat(i, 0, 0);
            @(negedge clk);
        end
        bus.src_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("midrst");
        repeat (20) @(negedge clk);
        chk("midrst_no_wb", 64'(wb_obs.size()), 64'd0);
        chk("midrst_idle", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        rst             = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_vl      = '0;
        bus.cmd_sew     = '0;
        bus.cmd_opSel   = '0;
        bus.cmd_vd_addr = '0;
        bus.src_valid   = 1'b0;
        bus.src_vec0    = '0;
        bus.src_vec1    = '0;
        resp_idx        = 0;
        cur_sew         = 0;
        cur_op          = 0;
        saw_last        = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;

        run_cmd(8, 0, 0, 32'h0000_0100, 0, 0);
        run_cmd(3, 3, 0, 32'h0000_0200, 2, 32'b101);
        run_cmd(72, 0, 0, 32'h0000_0300, 0, 0);
        run_cmd(5, 0, 0, 32'h0000_0400, 0, 0);
        run_cmd(0, 0, 0, 32'h0000_0500, 0, 0);
        mid_reset_test();
        run_cmd(64, 0, 1, 32'hFFFF_FFFF, 1, 0);

        for (int n = 0; n < 40; n++) begin
            int r, vl;
            r = $urandom_range(0, 9);
            if (r == 0)      vl = 0;
            else if (r < 3)  vl = $urandom_range(129, 400);
            else             vl = $urandom_range(1, 128);
            run_cmd(vl, $urandom_range(0, 3), $urandom_range(0, 1),
                    $urandom, $urandom_range(0, 1), 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
